adpll_loop_ctrl: RTL and testbench

- Digital loop controller that consumes the PFD's flagU/flagD and drives the DCO control code, closing the ADPLL loop.
- Runs on the reference clock IN_clk.
- Performs binary-search frequency acquisition, then switches to decimated ±1 phase tracking and reports lock.
- Sits between the PFD and the DCO; the higher dco_code value gives the higher DCO frequency.

---
 rtl/adpll_loop_ctrl_if.sv | 23 ++
 rtl/adpll_loop_ctrl.sv | 177 +++++++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/adpll_loop_ctrl_if.sv
// rtl/adpll_loop_ctrl_if.sv - PFD/DCO signal bundle for the ADPLL loop controller
// Purpose: groups the loop controller's enable, PFD flags and DCO/status outputs.
// Signals:
//   enable   - loop enable, sampled on IN_clk
//   flagU    - PFD up flag (feedback lags, frequency must rise)
//   flagD    - PFD down flag (feedback leads, frequency must fall)
//   dco_code - DCO control word, CODE_W bits, higher code = higher frequency
//   locked   - loop-lock indicator
//   state    - controller state: 0 = IDLE, 1 = ACQ, 2 = TRK
// Modports: master drives enable/flags (PFD/system side), slave is the controller.
interface adpll_loop_ctrl_if #(
  parameter int CODE_W = 8
);
  logic              enable;
  logic              flagU;
  logic              flagD;
  logic [CODE_W-1:0] dco_code;
  logic              locked;
  logic [1:0]        state;

  modport master (output enable, flagU, flagD, input dco_code, locked, state);
  modport slave  (input enable, flagU, flagD, output dco_code, locked, state);
endinterface

// File: rtl/adpll_loop_ctrl.sv
// rtl/adpll_loop_ctrl.sv - ADPLL loop controller: binary-search acquisition, decimated tracking, lock detect
// Purpose: turns synchronized PFD up/down flags into a DCO control code.
// Ports:
//   IN_clk - reference clock, all state updates on its rising edge
//   reset  - asynchronous active-low reset
//   bus    - adpll_loop_ctrl_if.slave: enable, flagU, flagD in; dco_code, locked, state out
module adpll_loop_ctrl #(
  parameter int CODE_W    = 8,
  parameter int INIT_CODE = 128,
  parameter int MAX_STEP  = 32,
  parameter int TRK_TH    = 4,
  parameter int LOCK_CNT  = 16,
  parameter int RELOCK_N  = 4
) (
  input  logic             IN_clk,
  input  logic             reset,
  adpll_loop_ctrl_if.slave bus
);
  localparam int AW = $clog2(TRK_TH) + 2;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(RELOCK_N + 1);

  localparam logic [CODE_W-1:0]    C_INIT       = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0]    C_MAX_STEP   = CODE_W'(MAX_STEP);
  localparam logic [CODE_W-1:0]    C_REACQ_STEP = CODE_W'(4);
  localparam logic [CODE_W-1:0]    C_ONE        = CODE_W'(1);
  localparam logic signed [AW-1:0] C_ACC_TH     = AW'(TRK_TH);
  localparam logic signed [AW-1:0] C_ACC_ONE    = AW'(1);
  localparam logic [LW-1:0]        C_LOCK       = LW'(LOCK_CNT);
  localparam logic [RW-1:0]        C_RELOCK     = RW'(RELOCK_N);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_TRK = 2'd2} state_t;
  typedef enum logic [1:0] {D_NONE = 2'd0, D_UP = 2'd1, D_DN = 2'd2} dir_t;

  state_t                r_state, w_state_nxt;
  logic [CODE_W-1:0]     r_code, w_code_nxt;
  logic [CODE_W-1:0]     r_step, w_step_nxt;
  dir_t                  r_prev, w_prev_nxt;
  logic signed [AW-1:0]  r_acc, w_acc_nxt, w_acc_sum;
  logic [LW-1:0]         r_lock_cnt, w_lock_nxt;
  logic [RW-1:0]         r_relock_cnt, w_relock_nxt, w_relock_inc;
  logic                  r_u_meta, r_u_sync, r_d_meta, r_d_sync;
  logic                  w_up, w_dn;
  dir_t                  w_dir;

  // Saturating code move; a clamped move is still reported as a move by the caller.
  function automatic logic [CODE_W-1:0] f_move(input logic [CODE_W-1:0] code,
                                               input logic up,
                                               input logic [CODE_W-1:0] amt);
    logic [CODE_W:0] sum;
    sum = '0;
    if (up) begin
      sum    = {1'b0, code} + {1'b0, amt};
      f_move = sum[CODE_W] ? '1 : sum[CODE_W-1:0];
    end else begin
      f_move = (amt > code) ? '0 : code - amt;
    end
  endfunction

  assign w_up = r_u_sync & ~r_d_sync;
  assign w_dn = r_d_sync & ~r_u_sync;

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_step_nxt   = r_step;
    w_prev_nxt   = r_prev;
    w_acc_nxt    = r_acc;
    w_lock_nxt   = r_lock_cnt;
    w_relock_nxt = r_relock_cnt;
    w_dir        = w_up ? D_UP : D_DN;
    w_acc_sum    = r_acc;
    if (w_up) begin
      w_acc_sum = r_acc + C_ACC_ONE;
    end else if (w_dn) begin
      w_acc_sum = r_acc - C_ACC_ONE;
    end
    // In TRK r_prev holds the direction of the last code update; a zero count means no run yet.
    w_relock_inc = (r_relock_cnt != '0 && r_prev == w_dir) ? r_relock_cnt + RW'(1) : RW'(1);

    if (!bus.enable) begin
      w_state_nxt  = S_IDLE;
      w_code_nxt   = C_INIT;
      w_step_nxt   = C_MAX_STEP;
      w_prev_nxt   = D_NONE;
      w_acc_nxt    = '0;
      w_lock_nxt   = '0;
      w_relock_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
          w_step_nxt  = C_MAX_STEP;
          w_prev_nxt  = D_NONE;
        end
        S_ACQ: begin
          if (w_up || w_dn) begin
            w_prev_nxt = w_dir;
            if (r_prev != D_NONE && r_prev != w_dir) begin
              if (r_step > C_ONE) begin
                w_step_nxt = r_step >> 1;
                w_code_nxt = f_move(r_code, w_up, r_step >> 1);
              end else begin
                // Search has converged to a single LSB: hand over to tracking.
                w_state_nxt  = S_TRK;
                w_acc_nxt    = '0;
                w_lock_nxt   = '0;
                w_relock_nxt = '0;
              end
            end else begin
              w_code_nxt = f_move(r_code, w_up, r_step);
            end
          end
        end
        S_TRK: begin
          if (r_lock_cnt != C_LOCK) begin
            w_lock_nxt = r_lock_cnt + LW'(1);
          end
          w_acc_nxt = w_acc_sum;
          // The accumulator moves by one per decision, so +TH is only reachable on UP.
          if (w_acc_sum == C_ACC_TH || w_acc_sum == -C_ACC_TH) begin
            w_acc_nxt    = '0;
            w_code_nxt   = f_move(r_code, w_up, C_ONE);
            w_prev_nxt   = w_dir;
            w_relock_nxt = w_relock_inc;
            if (w_relock_inc == C_RELOCK) begin
              // A long one-sided run means frequency has drifted: search again with a small step.
              w_state_nxt  = S_ACQ;
              w_step_nxt   = C_REACQ_STEP;
              w_lock_nxt   = '0;
              w_relock_nxt = '0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge IN_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge IN_clk or negedge reset) begin
    if (!reset) begin
      r_code       <= C_INIT;
      r_step       <= C_MAX_STEP;
      r_prev       <= D_NONE;
      r_acc        <= '0;
      r_lock_cnt   <= '0;
      r_relock_cnt <= '0;
      r_u_meta     <= 1'b0;
      r_u_sync     <= 1'b0;
      r_d_meta     <= 1'b0;
      r_d_sync     <= 1'b0;
    end else begin
      r_code       <= w_code_nxt;
      r_step       <= w_step_nxt;
      r_prev       <= w_prev_nxt;
      r_acc        <= w_acc_nxt;
      r_lock_cnt   <= w_lock_nxt;
      r_relock_cnt <= w_relock_nxt;
      r_u_meta     <= bus.flagU;
      r_u_sync     <= r_u_meta;
      r_d_meta     <= bus.flagD;
      r_d_sync     <= r_d_meta;
    end
  end

  assign bus.dco_code = r_code;
  assign bus.locked   = (r_lock_cnt == C_LOCK);
  assign bus.state    = r_state;
endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// tb/tb_adpll_loop_ctrl.sv - self-checking bench for adpll_loop_ctrl
module tb_adpll_loop_ctrl;
  logic IN_clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  adpll_loop_ctrl_if #(.CODE_W(8)) bus ();

  adpll_loop_ctrl #(
    .CODE_W(8), .INIT_CODE(128), .MAX_STEP(32), .TRK_TH(4), .LOCK_CNT(16), .RELOCK_N(4)
  ) dut (
    .IN_clk(IN_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 IN_clk = ~IN_clk;

  // Reference model: mode 0/1/2, code as plain int, directions as +1/-1/0.
  int         m_mode, m_code, m_step, m_prev, m_acc, m_lock, m_rel, m_last;
  logic [1:0] m_flags[$];

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_code = 128; m_step = 32; m_prev = 0;
    m_acc = 0; m_lock = 0; m_rel = 0; m_last = 0;
    m_flags.delete();
    m_flags.push_back(2'b00);
    m_flags.push_back(2'b00);
  endtask

  // Flags sampled at an edge become a decision two edges later.
  task automatic model_edge(input logic en, input logic u, input logic d);
    logic [1:0] f;
    int dir;
    f = m_flags.pop_front();
    m_flags.push_back({u, d});
    dir = (f == 2'b10) ? 1 : (f == 2'b01) ? -1 : 0;
    if (!en) begin
      m_mode = 0; m_code = 128; m_step = 32; m_prev = 0;
      m_acc = 0; m_lock = 0; m_rel = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_step = 32; m_prev = 0;
    end else if (m_mode == 1) begin
      if (dir != 0) begin
        if (m_prev == -dir) begin
          if (m_step > 1) begin
            m_step = m_step / 2;
            m_code = clamp(m_code + dir * m_step);
          end else begin
            m_mode = 2; m_acc = 0; m_lock = 0; m_rel = 0;
          end
        end else begin
          m_code = clamp(m_code + dir * m_step);
        end
        m_prev = dir;
      end
    end else begin
      if (m_lock < 16) m_lock++;
      m_acc += dir;
      if (m_acc == 4 || m_acc == -4) begin
        m_acc  = 0;
        m_code = clamp(m_code + dir);
        m_rel  = (m_rel > 0 && m_last == dir) ? m_rel + 1 : 1;
        m_last = dir;
        if (m_rel == 4) begin
          m_mode = 1; m_step = 4; m_prev = dir; m_lock = 0; m_rel = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en, input logic u, input logic d);
    bus.enable = en;
    bus.flagU  = u;
    bus.flagD  = d;
    @(posedge IN_clk);
    model_edge(en, u, d);
    cyc++;
    @(negedge IN_clk);
    chk($sformatf("code@%0d", cyc), 32'(bus.dco_code), 32'(m_code));
    chk($sformatf("state@%0d", cyc), 32'(bus.state), 32'(m_mode));
    chk($sformatf("locked@%0d", cyc), 32'(bus.locked), 32'((m_mode == 2 && m_lock == 16) ? 1 : 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.flagU  = 1'b0;
    bus.flagD  = 1'b0;
    model_reset();
    repeat (2) @(negedge IN_clk);
    chk("rst_code", 32'(bus.dco_code), 32'd128);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    reset = 1'b1;

    // Held UP: 160, 192, 224, then clamp at 255 while staying in ACQ.
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
    chk("sat_hi_code", 32'(bus.dco_code), 32'd255);
    chk("sat_hi_state", 32'(bus.state), 32'd1);

    tick(1'b0, 1'b0, 1'b0);
    chk("dis_code", 32'(bus.dco_code), 32'd128);
    chk("dis_state", 32'(bus.state), 32'd0);
    tick(1'b0, 1'b0, 1'b0);

    // Alternating UP/DN: 160,144,152,148,150,149 then TRK at 149.
    for (int i = 0; i < 7; i++) tick(1'b1, (i % 2) == 0, (i % 2) == 1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("trk_entry_state", 32'(bus.state), 32'd2);
    chk("trk_entry_code", 32'(bus.dco_code), 32'd149);

    // HOLD in TRK: lock asserts on the 16th decision.
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b1);
    chk("lock_early", 32'(bus.locked), 32'd0);
    tick(1'b1, 1'b1, 1'b1);
    chk("lock_16", 32'(bus.locked), 32'd1);
    chk("lock_code", 32'(bus.dco_code), 32'd149);

    // Held UP in TRK: +1 every 4 decisions, 4th update forces reacquisition with step 4.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    chk("trk_inc_code", 32'(bus.dco_code), 32'd150);
    chk("trk_inc_state", 32'(bus.state), 32'd2);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
    chk("relock_state", 32'(bus.state), 32'd1);
    chk("relock_code", 32'(bus.dco_code), 32'd153);
    chk("relock_locked", 32'(bus.locked), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("reacq_step4", 32'(bus.dco_code), 32'd161);

    // Back into TRK, then disable: IDLE at 128 and flags ignored.
    for (int i = 0; i < 40 && m_mode != 2; i++) tick(1'b1, (i % 2) == 0, (i % 2) == 1);
    chk("t6_trk", 32'(bus.state), 32'd2);
    tick(1'b0, 1'b1, 1'b0);
    chk("t6_idle_state", 32'(bus.state), 32'd0);
    chk("t6_idle_code", 32'(bus.dco_code), 32'd128);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Asynchronous reset while tracking.
    for (int i = 0; i < 60 && m_mode != 2; i++) tick(1'b1, (i % 2) == 0, (i % 2) == 1);
    chk("ar_pre_state", 32'(bus.state), 32'd2);
    reset = 1'b0;
    #1;
    chk("ar_code", 32'(bus.dco_code), 32'd128);
    chk("ar_state", 32'(bus.state), 32'd0);
    chk("ar_locked", 32'(bus.locked), 32'd0);
    bus.enable = 1'b0;
    model_reset();
    @(negedge IN_clk);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Randomized segments with per-segment flag bias; segment 0 drives toward code 0.
    for (int s = 0; s < 8; s++) begin
      int pu, pd;
      pu = $urandom_range(10, 90);
      pd = $urandom_range(10, 90);
      if (s == 0) begin
        pu = 3;
        pd = 97;
      end
      for (int i = 0; i < 60; i++)
        tick(($urandom_range(0, 99) < 98), ($urandom_range(0, 99) < pu), ($urandom_range(0, 99) < pd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
